// File: rtl/led_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// led_ctrl_pkg : shared types and constants for the I2C LED controller
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package led_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_WAIT_RD = 3'd2,
    ST_SEND    = 3'd3,
    ST_DRAIN   = 3'd4,
    ST_LATCH   = 3'd5
  } sched_state_t;

  // Byte offsets of each colour inside one LED's 3-byte slot (WS2812 wire order).
  localparam int c_OFS_G = 0;
  localparam int c_OFS_R = 1;
  localparam int c_OFS_B = 2;

  localparam int c_BYTES_PER_LED     = 3;
  localparam int c_LATCH_CYCLES_DFLT = 3000;

  function automatic int led_nbytes(input int led_cnt);
    return c_BYTES_PER_LED * led_cnt;
  endfunction

endpackage

`default_nettype wire

// File: rtl/led_latch_timer.sv
// ----------------------------------------------------------------------------
// led_latch_timer : loadable down-counter, one-cycle expired pulse at zero
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module led_latch_timer #(
  parameter int CNT_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_expired
);

  logic [CNT_W-1:0] r_count;
  logic             r_active;

  // Loading N gives an expired pulse N cycles after the load edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count  <= '0;
      r_active <= 1'b0;
    end else if (i_start) begin
      r_count  <= i_load_val;
      r_active <= 1'b1;
    end else if (r_active) begin
      if (r_count == '0) begin
        r_active <= 1'b0;
      end else begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  assign o_expired = r_active && (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/led_frame_scheduler.sv
// ----------------------------------------------------------------------------
// led_frame_scheduler : WS2812 frame sequencer and colour-buffer port arbiter
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module led_frame_scheduler
  import led_ctrl_pkg::*;
#(
  parameter int LED_CNT      = 11,
  parameter int LATCH_CYCLES = c_LATCH_CYCLES_DFLT,
  parameter int ADDR_W       = $clog2(led_nbytes(LED_CNT))
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  output logic              wr_ack,
  input  logic              commit,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              byte_valid,
  output logic [7:0]        byte_data,
  input  logic              byte_ready,
  input  logic              ser_busy,
  output logic              busy,
  output logic              frame_done
);

  localparam int                c_NBYTES     = led_nbytes(LED_CNT);
  localparam logic [ADDR_W-1:0] c_ADDR_LIMIT = ADDR_W'(c_NBYTES);
  localparam logic [ADDR_W-1:0] c_LAST_IDX   = ADDR_W'(c_NBYTES - c_BYTES_PER_LED + c_OFS_B);
  localparam int                c_TMR_W      = $clog2(LATCH_CYCLES + 1);
  localparam logic [c_TMR_W-1:0] c_TMR_LOAD  = c_TMR_W'(LATCH_CYCLES - 1);

  sched_state_t      r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_idx, w_idx_nxt;
  logic              r_pending, w_pending_nxt;
  logic              r_byte_valid, w_byte_valid_nxt;
  logic [7:0]        r_byte_data, w_byte_data_nxt;
  logic              w_tmr_start;
  logic              w_tmr_expired;
  logic              w_frame_done;
  logic              w_fetch;
  logic              w_wr_grant;
  logic              w_wr_mem;

  led_latch_timer #(
    .CNT_W (c_TMR_W)
  ) u_latch_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start    (w_tmr_start),
    .i_load_val (c_TMR_LOAD),
    .o_expired  (w_tmr_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_idx        <= '0;
      r_pending    <= 1'b0;
      r_byte_valid <= 1'b0;
      r_byte_data  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_idx        <= w_idx_nxt;
      r_pending    <= w_pending_nxt;
      r_byte_valid <= w_byte_valid_nxt;
      r_byte_data  <= w_byte_data_nxt;
    end
  end

  // A commit in any cycle is remembered; the frame-start transitions consume it,
  // so any number of commits during one frame coalesce into one further frame.
  always_comb begin
    w_state_nxt      = r_state;
    w_idx_nxt        = r_idx;
    w_pending_nxt    = r_pending | commit;
    w_byte_valid_nxt = r_byte_valid;
    w_byte_data_nxt  = r_byte_data;
    w_tmr_start      = 1'b0;
    w_frame_done     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (commit || r_pending) begin
          w_state_nxt   = ST_FETCH;
          w_idx_nxt     = '0;
          w_pending_nxt = 1'b0;
        end
      end
      ST_FETCH: begin
        w_state_nxt = ST_WAIT_RD;
      end
      ST_WAIT_RD: begin
        w_byte_data_nxt  = mem_rdata;
        w_byte_valid_nxt = 1'b1;
        w_state_nxt      = ST_SEND;
      end
      ST_SEND: begin
        if (byte_ready) begin
          w_byte_valid_nxt = 1'b0;
          if (r_idx == c_LAST_IDX) begin
            w_state_nxt = ST_DRAIN;
          end else begin
            w_idx_nxt   = r_idx + 1'b1;
            w_state_nxt = ST_FETCH;
          end
        end
      end
      ST_DRAIN: begin
        if (!ser_busy) begin
          w_state_nxt = ST_LATCH;
          w_tmr_start = 1'b1;
        end
      end
      ST_LATCH: begin
        if (w_tmr_expired) begin
          w_frame_done = 1'b1;
          w_idx_nxt    = '0;
          if (r_pending || commit) begin
            w_state_nxt   = ST_FETCH;
            w_pending_nxt = 1'b0;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // The reader owns the port only in FETCH; writes are gated by rst_n so every
  // combinational output reads zero while reset is held.
  assign w_fetch    = (r_state == ST_FETCH);
  assign w_wr_grant = rst_n && wr_en && !w_fetch;
  assign w_wr_mem   = w_wr_grant && (wr_addr < c_ADDR_LIMIT);

  always_comb begin
    wr_ack    = w_wr_grant;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_fetch) begin
      mem_en   = 1'b1;
      mem_addr = r_idx;
    end else if (w_wr_mem) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = wr_addr;
      mem_wdata = wr_data;
    end
  end

  assign byte_valid = r_byte_valid;
  assign byte_data  = r_byte_data;
  assign busy       = (r_state != ST_IDLE);
  assign frame_done = w_frame_done;

endmodule

`default_nettype wire
